spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter CS_GAP, default 4: clk cycles between cs_n edges and SCLK activity, and idle gap after release; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
REQ-004 req  input  2  per-requester transaction request, level; bit i = requester i.
REQ-005 len0, len1  input  8 each  byte count for requester 0/1; 0 means 256 bytes.
REQ-006 tx_bytes  input  16  {byte for req1, byte for req0}; sampled at each byte start.
REQ-007 gnt  output  2  one-hot grant, held for whole transaction.
REQ-008 tx_ack  output  1  one-cycle pulse: granted requester's tx byte consumed, present next byte.
REQ-009 rx_byte  output  8  last received byte; rx_valid  output  1  one-cycle qualifier.
REQ-010 xfer_done  output  2  one-cycle pulse on bit i when requester i's transaction ends.
REQ-011 cs_n  output  2  chip-select per requester's device, active-low.
REQ-012 m_start  output  1 and m_mosi  output  8: start pulse and tx byte to the SPI master.
REQ-013 m_miso  input  8 and m_done  input  1: rx byte and one-cycle completion from the SPI master.

Function
REQ-014 States: IDLE, SETUP, START, WAIT, HOLD, GAP; exactly one active.
REQ-015 IDLE: if req != 0, arbitrate, drive gnt, latch length, drive cs_n[i]=0 next cycle, enter SETUP.
REQ-016 Arbitration is round-robin: single requester wins; both requesting -> requester not granted last wins; after reset requester 0 has priority.
REQ-017 SETUP lasts CS_GAP cycles, then START.
REQ-018 START lasts one cycle: m_start=1, m_mosi=granted tx byte, tx_ack=1; then WAIT.
REQ-019 WAIT: m_done ignored outside WAIT; on m_done, rx_byte<=m_miso and rx_valid=1 next cycle, decrement remaining count (9-bit).
REQ-020 After decrement, remaining != 0 -> START next cycle (back-to-back, cs_n stays low); remaining == 0 -> HOLD.
REQ-021 HOLD lasts CS_GAP cycles with cs_n low, then cs_n[i]=1, xfer_done[i]=1 for one cycle, gnt=0, enter GAP.
REQ-022 GAP lasts CS_GAP cycles with all cs_n high; then IDLE; no grant during GAP.
REQ-023 Length and grant are latched; req or len changes during a transaction have no effect until next arbitration.
REQ-024 Deassertion of req mid-transaction does not abort; transaction completes to full length.
REQ-025 At most one cs_n bit low at any time; cs_n low only while gnt same bit set.
REQ-026 m_start never asserted outside START; one m_start per byte exactly.
REQ-027 Requester whose req is still high after xfer_done competes again at next IDLE under REQ-016.

Reset
REQ-028 rst low forces immediately: state IDLE, gnt=0, cs_n=2'b11, m_start=0, tx_ack=0, rx_valid=0, xfer_done=0, rx_byte=0, m_mosi=0, priority pointer to requester 0.
REQ-029 Reset mid-transaction aborts without xfer_done; cs_n returns high asynchronously.
REQ-030 After rst release, first arbitration no earlier than the first rising clk edge with rst high.

Verification
REQ-031 req=01, len0=1, tx_bytes[7:0]=5A, m_miso=C3 -> cs_n=10, m_start 1 pulse with m_mosi=5A after 4 cycles, rx_byte=C3 rx_valid, 4 cycles later cs_n=11, xfer_done=01.
REQ-032 req=11 held, len0=len1=1 -> grants alternate 01,10,01; 4-cycle all-high gap between cs_n assertions.
REQ-033 len1=3, req=10 -> exactly 3 m_start pulses, 3 tx_ack, 3 rx_valid, cs_n[1] low continuously, one xfer_done=10.
REQ-034 len0=0 -> 256 m_start pulses before xfer_done=01.
REQ-035 rst low during WAIT of byte 2 -> cs_n=11 and gnt=00 without clk edge, no xfer_done; after release req=01 regranted normally.
REQ-036 Spurious m_done pulse in IDLE/GAP -> no rx_valid, no state change.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between two requesters with round-robin
// arbitration, per-device chip selects and CS_GAP setup/hold/idle spacing.
module spi_arbiter #(
    parameter int unsigned CS_GAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    input  logic [15:0] tx_bytes,
    output logic [1:0]  gnt,
    output logic        tx_ack,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic [1:0]  xfer_done,
    output logic [1:0]  cs_n,
    output logic        m_start,
    output logic [7:0]  m_mosi,
    input  logic [7:0]  m_miso,
    input  logic        m_done
);

    localparam logic [3:0] GapLast = 4'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStart,
        StWait,
        StHold,
        StGap
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] remain_q, remain_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] cs_n_q, cs_n_d;
    logic       prio_q, prio_d;      // 1: requester 1 wins on contention
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic [1:0] xfer_done_q, xfer_done_d;

    logic [1:0] win;
    logic [7:0] win_len;
    logic       launch;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = prio_q ? 2'b10 : 2'b01;
        end
        win_len = win[1] ? len1 : len0;
    end

    // Next-state logic. The last GAP cycle doubles as the arbitration cycle so
    // back-to-back transactions see exactly CS_GAP all-high cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remain_d    = remain_q;
        gnt_d       = gnt_q;
        cs_n_d      = cs_n_q;
        prio_d      = prio_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        xfer_done_d = 2'b00;
        launch      = 1'b0;

        unique case (state_q)
            StIdle: begin
                launch = (req != 2'b00);
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (m_done) begin
                    rx_byte_d  = m_miso;
                    rx_valid_d = 1'b1;
                    remain_d   = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        state_d = StHold;
                        cnt_d   = GapLast;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    cs_n_d      = 2'b11;
                    gnt_d       = 2'b00;
                    xfer_done_d = gnt_q;
                    state_d     = StGap;
                    cnt_d       = GapLast;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    launch  = (req != 2'b00);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            state_d  = StSetup;
            cnt_d    = GapLast;
            gnt_d    = win;
            cs_n_d   = ~win;
            prio_d   = win[0];
            remain_d = (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
        end
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            remain_q    <= 9'd0;
            gnt_q       <= 2'b00;
            cs_n_q      <= 2'b11;
            prio_q      <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            xfer_done_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remain_q    <= remain_d;
            gnt_q       <= gnt_d;
            cs_n_q      <= cs_n_d;
            prio_q      <= prio_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    // Master-side strobes decode straight from the state so they are exactly one per START.
    always_comb begin
        m_start = (state_q == StStart);
        tx_ack  = m_start;
        m_mosi  = 8'h00;
        if (m_start) begin
            m_mosi = gnt_q[1] ? tx_bytes[15:8] : tx_bytes[7:0];
        end
    end

    assign gnt       = gnt_q;
    assign cs_n      = cs_n_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign xfer_done = xfer_done_q;

endmodule
